// File: rtl/video_pattern_pkg.sv
// Shared constants for the video test-pattern source: pattern codes, colour-bar
// palette, moving-bar geometry and helpers for raster-dependent constants.
package video_pattern_pkg;

    typedef enum logic [2:0] {
        PAT_BARS       = 3'd0,
        PAT_RAMP       = 3'd1,
        PAT_CHECKER    = 3'd2,
        PAT_MOVING_BAR = 3'd3,
        PAT_RED        = 3'd4,
        PAT_GREEN      = 3'd5,
        PAT_BLUE       = 3'd6,
        PAT_BORDER     = 3'd7
    } pattern_e;

    // {R,G,B}; index 0 is the left-most bar.
    localparam logic [0:7][23:0] BAR_RGB = {
        24'hFF_FF_FF, 24'hFF_FF_00, 24'h00_FF_FF, 24'h00_FF_00,
        24'hFF_00_FF, 24'hFF_00_00, 24'h00_00_FF, 24'h00_00_00
    };

    localparam int unsigned MOVING_BAR_WIDTH = 16;
    localparam int unsigned MOVING_BAR_STEP  = 4;

    function automatic int unsigned ramp_k(input int unsigned h_active);
        return (32'd1 << 24) / h_active;
    endfunction

    function automatic int unsigned bar_width(input int unsigned h_active);
        return h_active / 8;
    endfunction

endpackage

// File: rtl/video_pattern_sequencer.sv
// Frame-level state: vSync edge detection, frame counter, moving-bar position
// and the pattern selection that is latched once per frame.
module video_pattern_sequencer
    import video_pattern_pkg::*;
#(
    parameter int H_ACTIVE           = 1280,
    parameter int FRAMES_PER_PATTERN = 120
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        v_sync_in,
    input  logic        auto_cycle,
    input  logic [2:0]  pattern_select,
    output logic [2:0]  active_pattern,
    output logic [11:0] bar_x,
    output logic [7:0]  frame_count
);

    logic        v_sync_prev_q, v_sync_prev_d;
    logic [7:0]  frame_count_q, frame_count_d;
    logic [7:0]  dwell_q, dwell_d;
    logic [11:0] bar_x_q, bar_x_d;
    logic [2:0]  active_pattern_q, active_pattern_d;
    logic        frame_event;
    logic [12:0] bar_x_step;

    assign frame_event = v_sync_in & ~v_sync_prev_q;
    assign bar_x_step  = {1'b0, bar_x_q} + 13'(MOVING_BAR_STEP);

    always_comb begin
        v_sync_prev_d    = v_sync_in;
        frame_count_d    = frame_count_q;
        dwell_d          = dwell_q;
        bar_x_d          = bar_x_q;
        active_pattern_d = active_pattern_q;
        if (frame_event) begin
            frame_count_d = frame_count_q + 8'd1;
            bar_x_d = (bar_x_step >= 13'(H_ACTIVE)) ? 12'(bar_x_step - 13'(H_ACTIVE))
                                                    : bar_x_step[11:0];
            if (auto_cycle) begin
                // The dwell counter reaching its last frame is what releases the step.
                if (dwell_q == 8'(FRAMES_PER_PATTERN - 1)) begin
                    active_pattern_d = active_pattern_q + 3'd1;
                    dwell_d          = 8'd0;
                end else begin
                    dwell_d = dwell_q + 8'd1;
                end
            end else begin
                active_pattern_d = pattern_select;
                dwell_d          = 8'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v_sync_prev_q    <= 1'b0;
            frame_count_q    <= 8'd0;
            dwell_q          <= 8'd0;
            bar_x_q          <= 12'd0;
            active_pattern_q <= PAT_BARS;
        end else begin
            v_sync_prev_q    <= v_sync_prev_d;
            frame_count_q    <= frame_count_d;
            dwell_q          <= dwell_d;
            bar_x_q          <= bar_x_d;
            active_pattern_q <= active_pattern_d;
        end
    end

    assign active_pattern = active_pattern_q;
    assign bar_x          = bar_x_q;
    assign frame_count    = frame_count_q;

endmodule

// File: rtl/video_pattern_generator.sv
// Two-stage RGB test-pattern datapath: stage 1 precomputes per-pixel features,
// stage 2 selects the pattern colour and applies blanking; syncs follow in step.
module video_pattern_generator
    import video_pattern_pkg::*;
#(
    parameter int H_ACTIVE           = 1280,
    parameter int V_ACTIVE           = 720,
    parameter int FRAMES_PER_PATTERN = 120
) (
    input  logic        pixelClock,
    input  logic        reset,
    input  logic [2:0]  patternSelect,
    input  logic        autoCycle,
    input  logic        dataEnableIn,
    input  logic        hSyncIn,
    input  logic        vSyncIn,
    input  logic [11:0] hPos,
    input  logic [10:0] vPos,
    output logic        dataEnable,
    output logic        hSync,
    output logic        vSync,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic [2:0]  activePattern,
    output logic [7:0]  frameCount
);

    localparam int unsigned BAR_WIDTH = bar_width(H_ACTIVE);
    localparam int unsigned RAMP_K    = ramp_k(H_ACTIVE);

    logic [2:0]  active_pattern;
    logic [11:0] bar_x;

    video_pattern_sequencer #(
        .H_ACTIVE           (H_ACTIVE),
        .FRAMES_PER_PATTERN (FRAMES_PER_PATTERN)
    ) u_sequencer (
        .clk            (pixelClock),
        .reset          (reset),
        .v_sync_in      (vSyncIn),
        .auto_cycle     (autoCycle),
        .pattern_select (patternSelect),
        .active_pattern (active_pattern),
        .bar_x          (bar_x),
        .frame_count    (frameCount)
    );

    logic        de_s1_q, de_s1_d;
    logic        hs_s1_q, hs_s1_d;
    logic        vs_s1_q, vs_s1_d;
    logic [2:0]  pat_s1_q, pat_s1_d;
    logic [2:0]  bar_idx_s1_q, bar_idx_s1_d;
    logic [7:0]  ramp_s1_q, ramp_s1_d;
    logic        checker_s1_q, checker_s1_d;
    logic        window_s1_q, window_s1_d;
    logic        border_s1_q, border_s1_d;

    logic        de_q, de_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic [23:0] rgb_q, rgb_d;

    always_comb begin
        de_s1_d      = dataEnableIn;
        hs_s1_d      = hSyncIn;
        vs_s1_d      = vSyncIn;
        // Pattern is captured with the pixel so a frame event never splits a pixel's features.
        pat_s1_d     = active_pattern;
        bar_idx_s1_d = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (hPos >= 12'(k * BAR_WIDTH)) bar_idx_s1_d = 3'(k);
        end
        ramp_s1_d    = 8'((32'(hPos) * 32'(RAMP_K)) >> 16);
        checker_s1_d = hPos[5] ^ vPos[5];
        window_s1_d  = ({1'b0, hPos} >= {1'b0, bar_x}) &&
                       ({1'b0, hPos} <  {1'b0, bar_x} + 13'(MOVING_BAR_WIDTH));
        border_s1_d  = (hPos == 12'd0) || (hPos == 12'(H_ACTIVE - 1)) ||
                       (vPos == 11'd0) || (vPos == 11'(V_ACTIVE - 1));
    end

    always_comb begin
        de_d  = de_s1_q;
        hs_d  = hs_s1_q;
        vs_d  = vs_s1_q;
        rgb_d = 24'd0;
        case (pat_s1_q)
            PAT_BARS:       rgb_d = BAR_RGB[bar_idx_s1_q];
            PAT_RAMP:       rgb_d = {3{ramp_s1_q}};
            PAT_CHECKER:    rgb_d = checker_s1_q ? 24'hFF_FF_FF : 24'd0;
            PAT_MOVING_BAR: rgb_d = window_s1_q ? 24'hFF_FF_FF : 24'd0;
            PAT_RED:        rgb_d = 24'hFF_00_00;
            PAT_GREEN:      rgb_d = 24'h00_FF_00;
            PAT_BLUE:       rgb_d = 24'h00_00_FF;
            PAT_BORDER:     rgb_d = border_s1_q ? 24'hFF_FF_FF : 24'd0;
            default:        rgb_d = 24'd0;
        endcase
        if (!de_s1_q) rgb_d = 24'd0;
    end

    always_ff @(posedge pixelClock) begin
        if (reset) begin
            de_s1_q      <= 1'b0;
            hs_s1_q      <= 1'b0;
            vs_s1_q      <= 1'b0;
            pat_s1_q     <= PAT_BARS;
            bar_idx_s1_q <= 3'd0;
            ramp_s1_q    <= 8'd0;
            checker_s1_q <= 1'b0;
            window_s1_q  <= 1'b0;
            border_s1_q  <= 1'b0;
            de_q         <= 1'b0;
            hs_q         <= 1'b0;
            vs_q         <= 1'b0;
            rgb_q        <= 24'd0;
        end else begin
            de_s1_q      <= de_s1_d;
            hs_s1_q      <= hs_s1_d;
            vs_s1_q      <= vs_s1_d;
            pat_s1_q     <= pat_s1_d;
            bar_idx_s1_q <= bar_idx_s1_d;
            ramp_s1_q    <= ramp_s1_d;
            checker_s1_q <= checker_s1_d;
            window_s1_q  <= window_s1_d;
            border_s1_q  <= border_s1_d;
            de_q         <= de_d;
            hs_q         <= hs_d;
            vs_q         <= vs_d;
            rgb_q        <= rgb_d;
        end
    end

    assign dataEnable    = de_q;
    assign hSync         = hs_q;
    assign vSync         = vs_q;
    assign red           = rgb_q[23:16];
    assign green         = rgb_q[15:8];
    assign blue          = rgb_q[7:0];
    assign activePattern = active_pattern;

endmodule

// File: tb/tb_video_pattern_generator.sv
// Scoreboard bench for video_pattern_generator: a frame/pixel reference model
// predicts each output edge, and a monitor checks the DUT every cycle.
module tb_video_pattern_generator;

    localparam int H   = 1280;
    localparam int V   = 720;
    localparam int FPP = 2;

    logic        pixelClock = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  patternSelect = 3'd0;
    logic        autoCycle = 1'b0;
    logic        dataEnableIn = 1'b0;
    logic        hSyncIn = 1'b0;
    logic        vSyncIn = 1'b0;
    logic [11:0] hPos = 12'd0;
    logic [10:0] vPos = 11'd0;
    logic        dataEnable, hSync, vSync;
    logic [7:0]  red, green, blue;
    logic [2:0]  activePattern;
    logic [7:0]  frameCount;

    video_pattern_generator #(
        .H_ACTIVE           (H),
        .V_ACTIVE           (V),
        .FRAMES_PER_PATTERN (FPP)
    ) dut (
        .pixelClock    (pixelClock),
        .reset         (reset),
        .patternSelect (patternSelect),
        .autoCycle     (autoCycle),
        .dataEnableIn  (dataEnableIn),
        .hSyncIn       (hSyncIn),
        .vSyncIn       (vSyncIn),
        .hPos          (hPos),
        .vPos          (vPos),
        .dataEnable    (dataEnable),
        .hSync         (hSync),
        .vSync         (vSync),
        .red           (red),
        .green         (green),
        .blue          (blue),
        .activePattern (activePattern),
        .frameCount    (frameCount)
    );

    // ---------------- clock / edge counter ----------------
    always #5 pixelClock = ~pixelClock;

    int unsigned cyc = 0;
    always @(posedge pixelClock) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    // exp_q entry: {due_edge[31:0], de, hs, vs, rgb[23:0]}
    logic [58:0] exp_q[$];
    // st_q entry: {due_edge[31:0], pattern[2:0], frame_count[7:0]}
    logic [42:0] st_q[$];
    int checks = 0;
    int errors = 0;

    // reference model of frame-level state
    int m_fc = 0, m_pat = 0, m_dwell = 0, m_barx = 0;
    logic m_vs_prev = 1'b0;
    logic [2:0] sel_r = 3'd0;
    logic auto_r = 1'b0;

    logic [23:0] bar_tab[8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    function automatic logic [23:0] exp_rgb(input int pat, input int h, input int v, input int barx);
        int g;
        case (pat)
            0: return bar_tab[h / (H / 8)];
            1: begin
                g = (h * ((1 << 24) / H)) >> 16;
                return {3{8'(g)}};
            end
            2: return ((((h >> 5) ^ (v >> 5)) & 1) != 0) ? 24'hFFFFFF : 24'h0;
            3: return (h >= barx && h < barx + 16) ? 24'hFFFFFF : 24'h0;
            4: return 24'hFF0000;
            5: return 24'h00FF00;
            6: return 24'h0000FF;
            default: return (h == 0 || h == H - 1 || v == 0 || v == V - 1) ? 24'hFFFFFF : 24'h0;
        endcase
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input logic rst, input logic de, input logic hs, input logic vs,
                         input int h, input int v);
        int unsigned k;
        logic [23:0] rgb;
        @(negedge pixelClock);
        reset = rst; dataEnableIn = de; hSyncIn = hs; vSyncIn = vs;
        hPos = 12'(h); vPos = 11'(v);
        patternSelect = sel_r; autoCycle = auto_r;
        k = cyc + 1;
        if (rst) begin
            // reset clears the output on this edge and the stage-1 contents shown next edge
            if (exp_q.size() > 0 && exp_q[exp_q.size()-1][58:27] == k)
                exp_q[exp_q.size()-1] = {k, 27'd0};
            else
                exp_q.push_back({k, 27'd0});
            exp_q.push_back({k + 1, 27'd0});
            m_fc = 0; m_pat = 0; m_dwell = 0; m_barx = 0; m_vs_prev = 1'b0;
        end else begin
            rgb = de ? exp_rgb(m_pat, h, v, m_barx) : 24'd0;
            exp_q.push_back({k + 1, de, hs, vs, rgb});
            if (vs && !m_vs_prev) begin
                m_fc = (m_fc + 1) % 256;
                m_barx = (m_barx + 4 >= H) ? m_barx + 4 - H : m_barx + 4;
                if (auto_r) begin
                    if (m_dwell == FPP - 1) begin m_pat = (m_pat + 1) % 8; m_dwell = 0; end
                    else m_dwell++;
                end else begin
                    m_pat = int'(sel_r); m_dwell = 0;
                end
            end
            m_vs_prev = vs;
        end
        st_q.push_back({k, 3'(m_pat), 8'(m_fc)});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic frame(input int len);
        for (int i = 0; i < len; i++) drive(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b1, 0, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic px(input int h, input int v);
        drive(1'b0, 1'b1, 1'b0, 1'b0, h, v);
    endtask

    task automatic rand_px(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 5) == 0)
                drive(1'b0, 1'b0, 1'b1, 1'b0, $urandom_range(0, H - 1), $urandom_range(0, V - 1));
            else
                px($urandom_range(0, H - 1), $urandom_range(0, V - 1));
        end
    endtask

    function automatic int clip(input int h);
        return (h < 0) ? 0 : ((h > H - 1) ? H - 1 : h);
    endfunction

    // ---------------- monitor ----------------
    initial begin
        logic [58:0] e;
        logic [42:0] s;
        forever begin
            @(posedge pixelClock);
            #1;
            while (exp_q.size() > 0 && exp_q[0][58:27] <= cyc) begin
                e = exp_q.pop_front();
                checks++;
                if (e[58:27] != cyc || {dataEnable, hSync, vSync, red, green, blue} != e[26:0]) begin
                    errors++;
                    $display("FAIL pixel edge=%0d due=%0d got de/hs/vs=%b%b%b rgb=%h expected de/hs/vs=%b rgb=%h",
                             cyc, e[58:27], dataEnable, hSync, vSync, {red, green, blue}, e[26:24], e[23:0]);
                end
            end
            while (st_q.size() > 0 && st_q[0][42:11] <= cyc) begin
                s = st_q.pop_front();
                checks++;
                if (s[42:11] != cyc || {activePattern, frameCount} != s[10:0]) begin
                    errors++;
                    $display("FAIL status edge=%0d got pattern=%0d frameCount=%0d expected pattern=%0d frameCount=%0d",
                             cyc, activePattern, frameCount, s[10:8], s[7:0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        idle(2);

        // colour bars with directed columns
        sel_r = 3'd0; auto_r = 1'b0;
        frame(2);
        px(0, 100); px(320, 100); px(1279, 100); px(159, 5); px(160, 5); px(1120, 5);
        rand_px(10);

        // grey ramp
        sel_r = 3'd1; frame(1);
        px(0, 10); px(640, 10); px(1279, 10); px(1, 10); rand_px(10);

        // checkerboard and border
        sel_r = 3'd2; frame(3); rand_px(15); px(31, 31); px(32, 31); px(32, 32);
        sel_r = 3'd7; frame(1);
        px(0, 300); px(1279, 300); px(500, 0); px(500, 719); px(1, 1); px(1278, 718); rand_px(8);

        // mid-frame select change: bars stay until the next frame event
        sel_r = 3'd0; frame(1); rand_px(5);
        sel_r = 3'd4; rand_px(6);
        frame(1); rand_px(6);
        sel_r = 3'd5; frame(2); rand_px(4);

        // moving bar over a full wrap, from a fresh reset
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        sel_r = 3'd3;
        for (int f = 0; f < 322; f++) begin
            frame(1 + $urandom_range(0, 2));
            px(clip(m_barx - 1), 50); px(m_barx, 50); px(clip(m_barx + 15), 50);
            px(clip(m_barx + 16), 50); px($urandom_range(1276, 1279), 50);
        end
        px(1275, 9); px(1276, 9); px(1279, 9);

        // auto-cycle with vSync held high for several cycles
        auto_r = 1'b1;
        for (int f = 0; f < 18; f++) begin
            frame(5); rand_px(3);
        end
        auto_r = 1'b0;

        // reset mid-line with solid blue active
        sel_r = 3'd6; frame(1); px(10, 20); px(700, 20);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 711, 20);
        px(0, 20); px(400, 20); px(1279, 20); rand_px(3);
        frame(1); rand_px(4);

        // randomized frames
        for (int f = 0; f < 40; f++) begin
            sel_r = 3'($urandom_range(0, 7));
            auto_r = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) drive(1'b1, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 0, 0);
            frame($urandom_range(1, 5));
            rand_px($urandom_range(3, 10));
        end

        idle(3);
        repeat (3) @(posedge pixelClock);
        #2;
        checks++;
        if (exp_q.size() != 0 || st_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending pixel=%0d status=%0d expected 0 and 0", exp_q.size(), st_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
